recovery_pc_restore: RTL

//  Read side of the ECC-protected recovery PC register. After a fault, the HMR

---
 rtl/recovery_pc_restore.sv | 116 +++++++++++
 1 files changed

// File: rtl/recovery_pc_restore.sv
// Restore sequencer for the ECC-protected recovery PC: reads the backup, halts the core
// and hands the resume address over a valid/ack PC-set handshake, with a bounded wait.
module recovery_pc_restore #(
    parameter int unsigned DataWidth  = 32,
    parameter int unsigned AckTimeout = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    output logic                 recovery_read_enable_o,
    input  logic [DataWidth-1:0] recovery_program_counter_i,
    input  logic                 recovery_branch_i,
    input  logic [DataWidth-1:0] recovery_branch_addr_i,
    output logic                 backup_write_inhibit_o,
    output logic                 backup_clear_o,
    output logic                 core_halt_o,
    input  logic                 core_halted_i,
    output logic                 core_pc_set_o,
    output logic [DataWidth-1:0] core_pc_value_o,
    input  logic                 core_pc_ack_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 error_o
);
    localparam int unsigned CntWidth = $clog2(AckTimeout);
    localparam logic [CntWidth-1:0] CntMax = CntWidth'(AckTimeout - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        READ      = 3'd1,
        WAIT_HALT = 3'd2,
        SET_PC    = 3'd3,
        DONE      = 3'd4
    } state_e;

    state_e                 state_q, state_d;
    logic [DataWidth-1:0]   target_q, target_d;
    logic [CntWidth-1:0]    cnt_q, cnt_d;
    logic                   error_q, error_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            target_q <= '0;
            cnt_q    <= '0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            cnt_q    <= cnt_d;
            error_q  <= error_d;
        end
    end

    // The awaited input is tested before the timeout so a late arrival still succeeds.
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        cnt_d    = cnt_q;
        error_d  = error_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = READ;
                    error_d = 1'b0;
                end
            end
            READ: begin
                target_d = recovery_branch_i ? recovery_branch_addr_i
                                             : recovery_program_counter_i;
                cnt_d    = '0;
                state_d  = WAIT_HALT;
            end
            WAIT_HALT: begin
                if (core_halted_i) begin
                    cnt_d   = '0;
                    state_d = SET_PC;
                end else if (cnt_q == CntMax) begin
                    error_d = 1'b1;
                    state_d = IDLE;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SET_PC: begin
                if (core_pc_ack_i) begin
                    state_d = DONE;
                end else if (cnt_q == CntMax) begin
                    error_d = 1'b1;
                    state_d = IDLE;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        recovery_read_enable_o = (state_q == READ);
        core_halt_o            = (state_q == WAIT_HALT) || (state_q == SET_PC);
        core_pc_set_o          = (state_q == SET_PC);
        done_o                 = (state_q == DONE);
        backup_clear_o         = (state_q == DONE);
        busy_o                 = (state_q != IDLE);
        backup_write_inhibit_o = (state_q != IDLE);
        core_pc_value_o        = target_q;
        error_o                = error_q;
    end

endmodule
